// File: rtl/rdma_sink_pkg.sv
// rdma_sink_pkg: shared widths, request/completion layouts and FSM states for the RDMA write sink.
package rdma_sink_pkg;
  localparam int DATA_BITS  = 512;
  localparam int REQ_BITS   = 96;
  localparam int LEN_BITS   = 28;
  localparam int PID_BITS   = 6;
  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int CPL_BITS   = 40;
  typedef enum logic [1:0] {IDLE, CMD, DATA, CPL} state_t;
  typedef struct packed {
    logic [12:0]         rsvd;
    logic                host;
    logic [PID_BITS-1:0] pid;
    logic [LEN_BITS-1:0] len;
    logic [47:0]         vaddr;
  } req_t;
  typedef struct packed {
    logic [4:0]          rsvd;
    logic                err;
    logic [PID_BITS-1:0] pid;
    logic [LEN_BITS-1:0] len;
  } cpl_t;
endpackage

// File: rtl/keep_popcount.sv
// keep_popcount: counts set bits of a 64-bit tkeep into a 7-bit byte count.
module keep_popcount (
  input  logic [63:0] keep_i,
  output logic [6:0]  cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 64; i++) cnt_o = cnt_o + 7'(keep_i[i]);
  end
endmodule

// File: rtl/rdma_wr_req_sink.sv
// rdma_wr_req_sink: turns RDMA write requests into host write commands, forwards exactly len
// payload bytes with regenerated tlast, and reports one completion per request.
module rdma_wr_req_sink
  import rdma_sink_pkg::*;
(
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_req_valid,
  output logic                    s_req_ready,
  input  logic [REQ_BITS-1:0]     s_req_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic [REQ_BITS-1:0]     m_cmd_data,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_BITS-1:0]    s_axis_tdata,
  input  logic [BEAT_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_BITS-1:0]    m_axis_tdata,
  output logic [BEAT_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_cpl_valid,
  input  logic                    m_cpl_ready,
  output logic [CPL_BITS-1:0]     m_cpl_data,
  output logic [15:0]             err_cnt
);
  state_t              state_q, state_d;
  req_t                req_q, req_d;
  logic [LEN_BITS-1:0] rem_q, rem_d, keep_len;
  logic                err_q, err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [6:0]          keep_cnt;
  logic                in_data, gen_last, beat_fire;
  keep_popcount u_pc (.keep_i(s_axis_tkeep), .cnt_o(keep_cnt));
  assign keep_len  = LEN_BITS'(keep_cnt);
  assign in_data   = state_q == DATA;
  assign gen_last  = rem_q <= keep_len;
  assign beat_fire = s_axis_tvalid && s_axis_tready;
  always_comb begin
    s_req_ready   = state_q == IDLE && !areset;
    m_cmd_valid   = state_q == CMD;
    m_cmd_data    = req_q;
    s_axis_tready = in_data && m_axis_tready;
    m_axis_tvalid = in_data && s_axis_tvalid;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tlast  = in_data && gen_last;
    m_cpl_valid   = state_q == CPL;
    m_cpl_data    = {5'b0, err_q, req_q.pid, req_q.len};
    err_cnt       = err_cnt_q;
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (s_req_valid && s_req_ready) begin
        req_d      = s_req_data;
        req_d.rsvd = '0;
        rem_d      = req_d.len;
        err_d      = 1'b0;
        state_d    = CMD;
      end
      CMD:  if (m_cmd_ready) state_d = req_q.len == '0 ? CPL : DATA;
      DATA: if (beat_fire) begin
        rem_d   = rem_q > keep_len ? rem_q - keep_len : '0;
        // excess stack data is not consumed: a late tlast or empty beat just flags the request
        err_d   = err_q | (s_axis_tlast != gen_last) | ~|s_axis_tkeep;
        state_d = gen_last ? CPL : DATA;
      end
      CPL:  if (m_cpl_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_cnt_d = (in_data && state_d == CPL && err_d && ~&err_cnt_q) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_rdma_wr_req_sink.sv
// tb_rdma_wr_req_sink: directed scenarios plus a randomized backpressure soak for rdma_wr_req_sink.
module tb_rdma_wr_req_sink;
  localparam int N = 200;
  localparam logic [63:0] ONES = '1;
  logic         aclk = 0, areset = 1;
  logic         s_req_valid = 0, s_req_ready;
  logic [95:0]  s_req_data = '0;
  logic         m_cmd_valid, m_cmd_ready = 0;
  logic [95:0]  m_cmd_data;
  logic         s_axis_tvalid = 0, s_axis_tready;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tlast = 0;
  logic         m_axis_tvalid, m_axis_tready = 0;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_cpl_valid, m_cpl_ready = 0;
  logic [39:0]  m_cpl_data;
  logic [15:0]  err_cnt;
  int errors = 0, checks = 0;
  int lens[N];

  always #5 aclk = ~aclk;

  rdma_wr_req_sink dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_data(m_cmd_data),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready), .m_cpl_data(m_cpl_data),
    .err_cnt(err_cnt)
  );

  task automatic tick;
    @(posedge aclk); #1;
  endtask

  task automatic beat(input logic [63:0] k, input logic l, input logic [31:0] tag);
    s_axis_tvalid = 1; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tdata = {480'b0, tag}; m_axis_tready = 1;
  endtask

  function automatic logic [95:0] mk(input int i);
    mk = {13'b0, 1'(i & 1), 6'(i % 64), 28'(lens[i]), 48'h1000 + 48'(i) * 48'd64};
  endfunction

  task automatic test_reset;
    areset = 1; tick; tick;
    @(negedge aclk);
    checks++; if ({s_req_ready, m_cmd_valid, s_axis_tready, m_axis_tvalid, m_cpl_valid} !== 5'b0) begin errors++; $display("FAIL rst_handshakes got=%b exp=00000", {s_req_ready, m_cmd_valid, s_axis_tready, m_axis_tvalid, m_cpl_valid}); end
    checks++; if (m_cmd_data !== 96'b0) begin errors++; $display("FAIL rst_cmd_data got=%h exp=0", m_cmd_data); end
    checks++; if (m_cpl_data !== 40'b0) begin errors++; $display("FAIL rst_cpl_data got=%h exp=0", m_cpl_data); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    tick; areset = 0;
    @(negedge aclk);
    checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", s_req_ready); end
    tick;
  endtask

  task automatic test_two_full;
    s_req_valid = 1; s_req_data = {13'h1ABC, 1'b0, 6'd3, 28'd128, 48'h1000};
    @(negedge aclk);
    checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL t1_req_ready got=%b exp=1", s_req_ready); end
    tick; s_req_valid = 0; m_cmd_ready = 1;
    @(negedge aclk);
    checks++; if (m_cmd_valid !== 1'b1) begin errors++; $display("FAIL t1_cmd_valid got=%b exp=1", m_cmd_valid); end
    checks++; if (m_cmd_data !== {13'h0, 1'b0, 6'd3, 28'd128, 48'h1000}) begin errors++; $display("FAIL t1_cmd_data got=%h exp=%h", m_cmd_data, {13'h0, 1'b0, 6'd3, 28'd128, 48'h1000}); end
    tick; m_cmd_ready = 0; beat(ONES, 0, 32'h11);
    @(negedge aclk);
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]} !== {1'b1, 1'b0, 32'h11}) begin errors++; $display("FAIL t1_beat1 got=%b/%b/%h exp=1/0/11", m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]); end
    tick; beat(ONES, 1, 32'h12);
    @(negedge aclk);
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]} !== {1'b1, 1'b1, 32'h12}) begin errors++; $display("FAIL t1_beat2 got=%b/%b/%h exp=1/1/12", m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]); end
    tick; s_axis_tvalid = 0; m_cpl_ready = 1;
    @(negedge aclk);
    checks++; if ({m_cpl_valid, m_cpl_data} !== {1'b1, 5'b0, 1'b0, 6'd3, 28'd128}) begin errors++; $display("FAIL t1_cpl got=%b/%h exp=1/%h", m_cpl_valid, m_cpl_data, {5'b0, 1'b0, 6'd3, 28'd128}); end
    tick; m_cpl_ready = 0;
  endtask

  task automatic test_partial;
    s_req_valid = 1; s_req_data = {13'h0, 1'b1, 6'd7, 28'd100, 48'h2000}; tick;
    s_req_valid = 0; m_cmd_ready = 1; tick;
    m_cmd_ready = 0; beat(ONES, 0, 32'h21);
    @(negedge aclk);
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL t2_beat1_last got=%b exp=0", m_axis_tlast); end
    tick; beat(64'h0000000F_FFFFFFFF, 1, 32'h22);
    @(negedge aclk);
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep} !== {2'b11, 64'h0000000F_FFFFFFFF}) begin errors++; $display("FAIL t2_beat2 got=%b/%b/%h exp=1/1/fffffffff", m_axis_tvalid, m_axis_tlast, m_axis_tkeep); end
    tick; s_axis_tvalid = 0; m_cpl_ready = 1;
    @(negedge aclk);
    checks++; if ({m_cpl_valid, m_cpl_data} !== {1'b1, 5'b0, 1'b0, 6'd7, 28'd100}) begin errors++; $display("FAIL t2_cpl got=%b/%h exp=1/%h", m_cpl_valid, m_cpl_data, {5'b0, 1'b0, 6'd7, 28'd100}); end
    tick; m_cpl_ready = 0;
  endtask

  task automatic test_len0;
    s_req_valid = 1; s_req_data = {13'h0, 1'b0, 6'd5, 28'd0, 48'h3000}; tick;
    s_req_valid = 0; m_cmd_ready = 1; beat(ONES, 1, 32'h31);
    @(negedge aclk);
    checks++; if ({m_cmd_valid, s_axis_tready, m_axis_tvalid} !== 3'b100) begin errors++; $display("FAIL t3_cmd_no_data got=%b exp=100", {m_cmd_valid, s_axis_tready, m_axis_tvalid}); end
    tick; m_cmd_ready = 0;
    @(negedge aclk);
    checks++; if ({m_cpl_valid, s_axis_tready, m_cpl_data} !== {2'b10, 5'b0, 1'b0, 6'd5, 28'd0}) begin errors++; $display("FAIL t3_cpl got=%b/%b/%h exp=1/0/%h", m_cpl_valid, s_axis_tready, m_cpl_data, {5'b0, 1'b0, 6'd5, 28'd0}); end
    m_cpl_ready = 1; tick; m_cpl_ready = 0; s_axis_tvalid = 0;
  endtask

  task automatic test_mismatch;
    s_req_valid = 1; s_req_data = {13'h0, 1'b0, 6'd9, 28'd64, 48'h4000}; tick;
    s_req_valid = 0; m_cmd_ready = 1; tick;
    m_cmd_ready = 0; beat(ONES, 0, 32'h41);
    @(negedge aclk);
    checks++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 3'b111) begin errors++; $display("FAIL t4_beat1 got=%b exp=111", {m_axis_tvalid, m_axis_tlast, s_axis_tready}); end
    tick; beat(ONES, 1, 32'h42);
    @(negedge aclk);
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b00) begin errors++; $display("FAIL t4_beat2_held got=%b exp=00", {s_axis_tready, m_axis_tvalid}); end
    checks++; if ({m_cpl_valid, m_cpl_data} !== {1'b1, 5'b0, 1'b1, 6'd9, 28'd64}) begin errors++; $display("FAIL t4_cpl_err got=%b/%h exp=1/%h", m_cpl_valid, m_cpl_data, {5'b0, 1'b1, 6'd9, 28'd64}); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL t4_err_cnt got=%0d exp=1", err_cnt); end
    m_cpl_ready = 1; tick; m_cpl_ready = 0;
    s_req_valid = 1; s_req_data = {13'h0, 1'b0, 6'd10, 28'd64, 48'h5000}; tick;
    s_req_valid = 0; m_cmd_ready = 1; tick; m_cmd_ready = 0;
    @(negedge aclk);
    checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]} !== {2'b11, 32'h42}) begin errors++; $display("FAIL t4_next_req_beat got=%b/%b/%h exp=1/1/42", m_axis_tvalid, m_axis_tlast, m_axis_tdata[31:0]); end
    tick; s_axis_tvalid = 0;
    @(negedge aclk);
    checks++; if ({m_cpl_valid, m_cpl_data[34], err_cnt} !== {2'b10, 16'd1}) begin errors++; $display("FAIL t4_next_cpl got=%b/%b/%0d exp=1/0/1", m_cpl_valid, m_cpl_data[34], err_cnt); end
    m_cpl_ready = 1; tick; m_cpl_ready = 0;
  endtask

  task automatic test_backpressure;
    logic [63:0] bk[$];
    logic        bl[$];
    longint total = 0, bytes = 0;
    int ri = 0, si = 0, ci = 0, oi = 0, pi = 0;
    logic req_f = 0, src_f = 0, cmd_st = 0, ax_st = 0, cpl_st = 0;
    logic [95:0] p_cmd;
    logic [576:0] p_ax;
    logic [39:0] p_cpl;
    for (int i = 0; i < N; i++) begin
      lens[i] = (i % 10 == 0) ? 0 : int'($urandom_range(1, 4096));
      total += lens[i];
      for (int b = 0; b * 64 < lens[i]; b++) begin
        int r = lens[i] - b * 64;
        bk.push_back(r >= 64 ? ONES : (64'd1 << r) - 64'd1);
        bl.push_back(r <= 64);
      end
    end
    for (int c = 0; c < 60000 && pi < N; c++) begin
      tick;
      if (req_f) ri++;
      if (src_f) si++;
      s_req_valid = ri < N;
      s_req_data = ri < N ? mk(ri) | {13'h1555, 83'b0} : '0;
      s_axis_tvalid = (s_axis_tvalid && !src_f) || (si < bk.size() && $urandom_range(0, 3) != 0);
      s_axis_tkeep = si < bk.size() ? bk[si] : '0;
      s_axis_tlast = si < bk.size() ? bl[si] : 1'b0;
      s_axis_tdata = {480'b0, 32'(si)};
      m_cmd_ready = 1'($urandom_range(0, 1));
      m_axis_tready = 1'($urandom_range(0, 1));
      m_cpl_ready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (cmd_st) begin checks++; if ({m_cmd_valid, m_cmd_data} !== {1'b1, p_cmd}) begin errors++; $display("FAIL bp_cmd_stable got=%b/%h exp=1/%h", m_cmd_valid, m_cmd_data, p_cmd); end end
      if (ax_st) begin checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, p_ax}) begin errors++; $display("FAIL bp_axis_stable got=%b/%h exp=1/%h", m_axis_tvalid, m_axis_tdata[31:0], p_ax[96:65]); end end
      if (cpl_st) begin checks++; if ({m_cpl_valid, m_cpl_data} !== {1'b1, p_cpl}) begin errors++; $display("FAIL bp_cpl_stable got=%b/%h exp=1/%h", m_cpl_valid, m_cpl_data, p_cpl); end end
      req_f = s_req_valid && s_req_ready;
      src_f = s_axis_tvalid && s_axis_tready;
      if (m_cmd_valid && m_cmd_ready) begin
        checks++; if (ci >= N || m_cmd_data !== mk(ci)) begin errors++; $display("FAIL bp_cmd[%0d] got=%h exp=%h", ci, m_cmd_data, ci < N ? mk(ci) : '0); end
        ci++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (oi >= bk.size() || {m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast} !== {32'(oi), bk[oi], bl[oi]}) begin errors++; $display("FAIL bp_beat[%0d] got=%h/%h/%b", oi, m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast); end
        bytes += $countones(m_axis_tkeep);
        oi++;
      end
      if (m_cpl_valid && m_cpl_ready) begin
        checks++; if (pi >= N || m_cpl_data !== {5'b0, 1'b0, 6'(pi % 64), 28'(lens[pi])}) begin errors++; $display("FAIL bp_cpl[%0d] got=%h exp=len %0d", pi, m_cpl_data, pi < N ? lens[pi] : 0); end
        pi++;
      end
      cmd_st = m_cmd_valid && !m_cmd_ready; p_cmd = m_cmd_data;
      ax_st = m_axis_tvalid && !m_axis_tready; p_ax = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      cpl_st = m_cpl_valid && !m_cpl_ready; p_cpl = m_cpl_data;
    end
    checks++; if (pi != N || ci != N) begin errors++; $display("FAIL bp_done got cpl=%0d cmd=%0d exp=%0d", pi, ci, N); end
    checks++; if (bytes != total || oi != bk.size()) begin errors++; $display("FAIL bp_bytes got=%0d/%0d beats exp=%0d/%0d", bytes, oi, total, bk.size()); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL bp_err_cnt got=%0d exp=1", err_cnt); end
    if (req_f) ri++;
    s_req_valid = 0; s_axis_tvalid = 0; m_cmd_ready = 0; m_axis_tready = 0; m_cpl_ready = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    s_req_valid = 1; s_req_data = {13'h0, 1'b0, 6'd12, 28'd256, 48'h6000}; tick;
    s_req_valid = 0; m_cmd_ready = 1; tick;
    m_cmd_ready = 0; beat(ONES, 0, 32'h61); tick;
    beat(ONES, 0, 32'h62); areset = 1; tick;
    @(negedge aclk);
    checks++; if ({m_cmd_valid, m_axis_tvalid, m_cpl_valid, s_axis_tready, s_req_ready} !== 5'b0) begin errors++; $display("FAIL rm_outputs got=%b exp=00000", {m_cmd_valid, m_axis_tvalid, m_cpl_valid, s_axis_tready, s_req_ready}); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rm_err_cnt got=%0d exp=0", err_cnt); end
    tick; areset = 0; s_axis_tvalid = 0;
    @(negedge aclk);
    checks++; if ({s_req_ready, m_cpl_valid} !== 2'b10) begin errors++; $display("FAIL rm_release got=%b exp=10", {s_req_ready, m_cpl_valid}); end
    tick;
  endtask

  initial begin
    test_reset;
    test_two_full;
    test_partial;
    test_len0;
    test_mismatch;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
